// File: rtl/pc_gen.sv
// pc_gen: front-end PC generator.
// Offers a sequential PC stream (PC+4) to fetch. A small direct-mapped BTB
// supplies taken-branch predictions. Backend redirects flush fetch and
// restart the stream.
module pc_gen #(
    parameter int unsigned   XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned   BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc_data,
    output logic            pc_pred_taken,
    output logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    input  logic            btb_upd_taken
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - 2 - IDX;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   cur_pc, pc_nx;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            hit;
    logic [XLEN-1:0] next_seq;

    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic [XLEN-1:0] upd_target;

    assign lk_idx     = cur_pc[2 +: IDX];
    assign lk_tag     = cur_pc[XLEN-1 : 2+IDX];
    assign upd_idx    = btb_upd_pc[2 +: IDX];
    assign upd_tag    = btb_upd_pc[XLEN-1 : 2+IDX];
    assign upd_target = btb_upd_target & ALIGN_MASK;

    // BTB lookup on the registered PC
    always_comb begin
        hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        next_seq = hit ? btb_target[lk_idx] : cur_pc + XLEN'(4);
    end

    assign pc_data       = cur_pc;
    assign pc_pred_taken = hit;
    assign pc_valid      = (state == RUN) && !redirect_valid;
    assign flush         = redirect_valid && !rst;

    // Next state and next PC: redirect beats accept
    always_comb begin
        state_nx = state;
        pc_nx    = cur_pc;
        if (redirect_valid) begin
            state_nx = RUN;
            pc_nx    = redirect_pc & ALIGN_MASK;
        end else begin
            case (state)
                BOOT:    state_nx = RUN;
                RUN:     if (pc_ready) pc_nx = next_seq;
                default: state_nx = BOOT;
            endcase
        end
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BOOT;
            cur_pc <= RESET_PC;
        end else begin
            state  <= state_nx;
            cur_pc <= pc_nx;
        end
    end

    // BTB valid bits: set on taken update, cleared on not-taken tag match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (btb_upd_valid) begin
            if (btb_upd_taken)
                btb_valid[upd_idx] <= 1'b1;
            else if (btb_tag[upd_idx] == upd_tag)
                btb_valid[upd_idx] <= 1'b0;
        end
    end

    // BTB tag/target storage, only meaningful where valid is set
    always_ff @(posedge clk) begin
        if (btb_upd_valid && btb_upd_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
// Inputs change and outputs are sampled just after the falling edge.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] pc_data;
    logic        pc_pred_taken;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic        btb_upd_taken;

    int passed = 0;
    int total  = 0;

    pc_gen #(
        .XLEN(32),
        .RESET_PC(32'h8000_0000),
        .BTB_ENTRIES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_valid(pc_valid),
        .pc_ready(pc_ready),
        .pc_data(pc_data),
        .pc_pred_taken(pc_pred_taken),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .btb_upd_valid(btb_upd_valid),
        .btb_upd_pc(btb_upd_pc),
        .btb_upd_target(btb_upd_target),
        .btb_upd_taken(btb_upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset and release, ending in RUN with pc_data = RESET_PC, pc_ready = 1
    task automatic do_reset();
        rst = 1'b1;
        pc_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        btb_upd_valid = 1'b0;
        btb_upd_pc = '0;
        btb_upd_target = '0;
        btb_upd_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1234_5678;
        btb_upd_valid = 1'b0;
        btb_upd_pc = '0;
        btb_upd_target = '0;
        btb_upd_taken = 1'b0;
        @(negedge clk);
        #1;
        total++; if (pc_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", pc_valid); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else passed++;
        total++; if (pc_pred_taken !== 1'b0) $display("FAIL reset_pred got %b want 0", pc_pred_taken); else passed++;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (pc_valid !== 1'b0) $display("FAIL boot_valid got %b want 0", pc_valid); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_valid !== 1'b1) $display("FAIL run_valid got %b want 1", pc_valid); else passed++;
        total++; if (pc_data !== 32'h8000_0000) $display("FAIL first_pc got %h want 80000000", pc_data); else passed++;
        total++; if (pc_pred_taken !== 1'b0) $display("FAIL first_pred got %b want 0", pc_pred_taken); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0004) $display("FAIL seq_pc1 got %h want 80000004", pc_data); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0008) $display("FAIL seq_pc2 got %h want 80000008", pc_data); else passed++;
        total++; if (pc_valid !== 1'b1) $display("FAIL seq_valid got %b want 1", pc_valid); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        pc_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (pc_data !== 32'h8000_0004) $display("FAIL stall_pc[%0d] got %h want 80000004", i, pc_data); else passed++;
            total++; if (pc_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, pc_valid); else passed++;
            @(negedge clk);
            #1;
        end
        pc_ready = 1'b1;
        #1;
        total++; if (pc_data !== 32'h8000_0004) $display("FAIL accept_pc got %h want 80000004", pc_data); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0008) $display("FAIL after_stall_pc got %h want 80000008", pc_data); else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        #1;
        total++; if (flush !== 1'b1) $display("FAIL redir_flush got %b want 1", flush); else passed++;
        total++; if (pc_valid !== 1'b0) $display("FAIL redir_valid got %b want 0", pc_valid); else passed++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h8000_0100) $display("FAIL redir_pc got %h want 80000100", pc_data); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL redir_flush_off got %b want 0", flush); else passed++;
        total++; if (pc_valid !== 1'b1) $display("FAIL redir_valid_on got %b want 1", pc_valid); else passed++;
        // held redirect: two flush cycles, last target wins
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        #1;
        total++; if (flush !== 1'b1) $display("FAIL hold_flush0 got %b want 1", flush); else passed++;
        @(negedge clk);
        redirect_pc = 32'h8000_0300;
        #1;
        total++; if (flush !== 1'b1) $display("FAIL hold_flush1 got %b want 1", flush); else passed++;
        total++; if (pc_valid !== 1'b0) $display("FAIL hold_valid got %b want 0", pc_valid); else passed++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h8000_0300) $display("FAIL hold_pc got %h want 80000300", pc_data); else passed++;
        // redirect during BOOT skips RESET_PC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h0000_1000) $display("FAIL boot_redir_pc got %h want 00001000", pc_data); else passed++;
        total++; if (pc_valid !== 1'b1) $display("FAIL boot_redir_valid got %b want 1", pc_valid); else passed++;
    endtask

    task automatic test_btb();
        do_reset();
        pc_ready = 1'b0;
        btb_upd_valid = 1'b1;
        btb_upd_pc = 32'h8000_0008;
        btb_upd_target = 32'h8000_0040;
        btb_upd_taken = 1'b1;
        @(negedge clk);
        btb_upd_valid = 1'b0;
        pc_ready = 1'b1;
        #1;
        total++; if (pc_data !== 32'h8000_0000 || pc_pred_taken !== 1'b0) $display("FAIL btb_s0 got %h/%b want 80000000/0", pc_data, pc_pred_taken); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0004 || pc_pred_taken !== 1'b0) $display("FAIL btb_s1 got %h/%b want 80000004/0", pc_data, pc_pred_taken); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0008 || pc_pred_taken !== 1'b1) $display("FAIL btb_s2 got %h/%b want 80000008/1", pc_data, pc_pred_taken); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_0040 || pc_pred_taken !== 1'b0) $display("FAIL btb_s3 got %h/%b want 80000040/0", pc_data, pc_pred_taken); else passed++;
        // not-taken update with aliasing tag must leave the entry alone
        pc_ready = 1'b0;
        btb_upd_valid = 1'b1;
        btb_upd_pc = 32'h8000_0028;
        btb_upd_taken = 1'b0;
        @(negedge clk);
        btb_upd_valid = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0008;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h8000_0008 || pc_pred_taken !== 1'b1) $display("FAIL alias_kept got %h/%b want 80000008/1", pc_data, pc_pred_taken); else passed++;
        // clearing update in the lookup cycle only takes effect afterwards
        btb_upd_valid = 1'b1;
        btb_upd_pc = 32'h8000_0008;
        btb_upd_taken = 1'b0;
        #1;
        total++; if (pc_pred_taken !== 1'b1) $display("FAIL same_cycle_pred got %b want 1", pc_pred_taken); else passed++;
        @(negedge clk);
        btb_upd_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h8000_0008 || pc_pred_taken !== 1'b0) $display("FAIL cleared_pred got %h/%b want 80000008/0", pc_data, pc_pred_taken); else passed++;
        pc_ready = 1'b1;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h8000_000C) $display("FAIL cleared_next got %h want 8000000c", pc_data); else passed++;
    endtask

    task automatic test_wrap_and_midreset();
        do_reset();
        pc_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        btb_upd_valid = 1'b1;
        btb_upd_pc = 32'h0000_0004;
        btb_upd_target = 32'h0000_0100;
        btb_upd_taken = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        btb_upd_valid = 1'b0;
        pc_ready = 1'b1;
        #1;
        total++; if (pc_data !== 32'hFFFF_FFFC || pc_pred_taken !== 1'b0) $display("FAIL wrap_pre got %h/%b want fffffffc/0", pc_data, pc_pred_taken); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h0000_0000) $display("FAIL wrap_pc got %h want 00000000", pc_data); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_data !== 32'h0000_0004 || pc_pred_taken !== 1'b1) $display("FAIL pre_rst_pred got %h/%b want 00000004/1", pc_data, pc_pred_taken); else passed++;
        rst = 1'b1;
        #1;
        total++; if (pc_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", pc_valid); else passed++;
        total++; if (pc_pred_taken !== 1'b0) $display("FAIL midrst_pred got %b want 0", pc_pred_taken); else passed++;
        total++; if (pc_data !== 32'h8000_0000) $display("FAIL midrst_pc got %h want 80000000", pc_data); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (pc_valid !== 1'b0) $display("FAIL midrst_boot got %b want 0", pc_valid); else passed++;
        @(negedge clk);
        #1;
        total++; if (pc_valid !== 1'b1 || pc_data !== 32'h8000_0000) $display("FAIL midrst_restart got %b/%h want 1/80000000", pc_valid, pc_data); else passed++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0004;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (pc_data !== 32'h0000_0004 || pc_pred_taken !== 1'b0) $display("FAIL btb_cleared got %h/%b want 00000004/0", pc_data, pc_pred_taken); else passed++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_btb();
        test_wrap_and_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
